// File: rtl/matmul_stream_engine_if.sv
// Ready/valid stream bundle used for both the operand input and the result output.
interface matmul_stream_engine_if #(
    parameter int W = 16
);
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tready;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/matmul_stream_engine.sv
// Streaming C = A*B engine: loads A (MxK) then B (KxN) from one input frame, computes one
// row of C at a time with N parallel MACs and streams C out row-major.
module matmul_stream_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cfg_signed,
    output logic                   busy,
    output logic                   done,
    output logic                   err_len,
    matmul_stream_engine_if.slave  s_axis,
    matmul_stream_engine_if.master m_axis
);
    localparam int AIW = (M * K > 1) ? $clog2(M * K) : 1;
    localparam int BIW = (K * N > 1) ? $clog2(K * N) : 1;
    localparam int MW  = (M > 1) ? $clog2(M) : 1;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int NW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUT} state_t;

    state_t            state;
    logic              cfg_q;
    logic [AIW-1:0]    a_ptr;
    logic [BIW-1:0]    b_ptr;
    logic [MW-1:0]     row;
    logic [KW-1:0]     kk;
    logic [NW-1:0]     col;
    logic [DATA_W-1:0] a_mem [2**AIW];
    logic [DATA_W-1:0] b_mem [2**BIW];
    logic [ACC_W-1:0]  acc      [N];
    logic [ACC_W-1:0]  acc_next [N];
    logic [ACC_W-1:0]  out_next;
    logic              s_hs, m_hs, last_in;

    assign s_hs    = s_axis.tvalid & s_axis.tready;
    assign m_hs    = m_axis.tvalid & m_axis.tready;
    assign last_in = (state == LOAD_B) && (b_ptr == BIW'(K * N - 1));

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x, input logic sgn);
        return {{(ACC_W - DATA_W){sgn & x[DATA_W-1]}}, x};
    endfunction

    // a_ptr walks A row-major across all rows; b_ptr holds k*N, the base of B row k.
    always_comb begin
        logic [BIW-1:0] b_addr;
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        b_addr   = '0;
        out_next = '0;
        for (int n = 0; n < N; n++) begin
            b_addr      = b_ptr + BIW'(n);
            acc_next[n] = ((kk == '0) ? '0 : acc[n])
                        + ext(a_mem[a_ptr], cfg_q) * ext(b_mem[b_addr], cfg_q);
        end
        for (int n = 1; n < N; n++)
            if (col == NW'(n - 1)) out_next = acc[n];
    end

    // NOTE: operand storage has no reset; every entry is rewritten before a job reads it.
    always_ff @(posedge clk) begin
        if (s_hs && state == LOAD_A) a_mem[a_ptr] <= s_axis.tdata;
        if (s_hs && state == LOAD_B) b_mem[b_ptr] <= s_axis.tdata;
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cfg_q         <= 1'b0;
            a_ptr         <= '0;
            b_ptr         <= '0;
            row           <= '0;
            kk            <= '0;
            col           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_len       <= 1'b0;
            s_axis.tready <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            for (int n = 0; n < N; n++) acc[n] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state         <= LOAD_A;
                    cfg_q         <= cfg_signed;
                    err_len       <= 1'b0;
                    busy          <= 1'b1;
                    s_axis.tready <= 1'b1;
                    a_ptr         <= '0;
                    b_ptr         <= '0;
                    row           <= '0;
                end
                LOAD_A: if (s_hs) begin
                    if (s_axis.tlast) begin
                        err_len       <= 1'b1;
                        busy          <= 1'b0;
                        s_axis.tready <= 1'b0;
                        state         <= IDLE;
                    end else if (a_ptr == AIW'(M * K - 1)) begin
                        a_ptr <= '0;
                        state <= LOAD_B;
                    end else begin
                        a_ptr <= a_ptr + 1'b1;
                    end
                end
                LOAD_B: if (s_hs) begin
                    if (last_in) begin
                        // A missing tlast on the final beat is flagged but the job still runs.
                        if (!s_axis.tlast) err_len <= 1'b1;
                        s_axis.tready <= 1'b0;
                        b_ptr         <= '0;
                        kk            <= '0;
                        state         <= COMPUTE;
                    end else if (s_axis.tlast) begin
                        err_len       <= 1'b1;
                        busy          <= 1'b0;
                        s_axis.tready <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        b_ptr <= b_ptr + 1'b1;
                    end
                end
                COMPUTE: begin
                    for (int n = 0; n < N; n++) acc[n] <= acc_next[n];
                    a_ptr <= a_ptr + 1'b1;
                    b_ptr <= b_ptr + BIW'(N);
                    if (kk == KW'(K - 1)) begin
                        kk            <= '0;
                        b_ptr         <= '0;
                        col           <= '0;
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= acc_next[0];
                        m_axis.tlast  <= (row == MW'(M - 1)) && (N == 1);
                        state         <= OUT;
                    end else begin
                        kk <= kk + 1'b1;
                    end
                end
                OUT: if (m_hs) begin
                    if (col == NW'(N - 1)) begin
                        m_axis.tvalid <= 1'b0;
                        m_axis.tlast  <= 1'b0;
                        if (row == MW'(M - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            row   <= row + 1'b1;
                            state <= COMPUTE;
                        end
                    end else begin
                        col          <= col + 1'b1;
                        m_axis.tdata <= out_next;
                        m_axis.tlast <= (row == MW'(M - 1)) && (col == NW'(N - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed bench for matmul_stream_engine: a 4x4x4 instance for the main scenarios and a
// 2x3x5 instance for the rectangular shape and end-to-end latency.
`timescale 1ns/1ps
module tb_matmul_stream_engine;
    logic clk = 1'b0;
    logic rst, start, cfg_signed, busy, done, err_len;
    logic start2, cfg2, busy2, done2, err2;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] a_v   [16];
    logic [15:0] b_v   [16];
    logic [31:0] c_exp [16];

    matmul_stream_engine_if #(.W(16)) s_if ();
    matmul_stream_engine_if #(.W(32)) m_if ();
    matmul_stream_engine_if #(.W(16)) s2_if ();
    matmul_stream_engine_if #(.W(32)) m2_if ();

    matmul_stream_engine #(.DATA_W(16), .ACC_W(32), .M(4), .K(4), .N(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_signed(cfg_signed), .busy(busy),
        .done(done), .err_len(err_len), .s_axis(s_if), .m_axis(m_if));

    matmul_stream_engine #(.DATA_W(16), .ACC_W(32), .M(2), .K(3), .N(5)) u_rect (
        .clk(clk), .rst(rst), .start(start2), .cfg_signed(cfg2), .busy(busy2),
        .done(done2), .err_len(err2), .s_axis(s2_if), .m_axis(m2_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model(input int mm, input int kd, input int nn, input bit sgn);
        logic [31:0] sum, ea, eb;
        for (int i = 0; i < mm; i++)
            for (int j = 0; j < nn; j++) begin
                sum = '0;
                for (int k = 0; k < kd; k++) begin
                    ea  = sgn ? 32'($signed(a_v[i*kd+k])) : 32'(a_v[i*kd+k]);
                    eb  = sgn ? 32'($signed(b_v[k*nn+j])) : 32'(b_v[k*nn+j]);
                    sum = sum + ea * eb;
                end
                c_exp[i*nn+j] = sum;
            end
    endtask

    task automatic send_beat(input logic [15:0] d, input bit l);
        int w = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        while (s_if.tready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_beat_timeout: s_axis_tready=%b, required 1", s_if.tready);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // One full 4x4x4 job against c_exp; bp toggles m_axis_tready every 3 cycles, poke pulses
    // start mid-COMPUTE, and cfg_signed is inverted after acceptance in every job.
    task automatic run_job(input bit sgn, input bit bp, input bit last_ok, input bit poke,
                           input string tag);
        int got, guard, lat;
        bit prev_stall;
        logic [31:0] prev_d;
        logic prev_l;
        @(negedge clk);
        start = 1'b1; cfg_signed = sgn;
        @(negedge clk);
        start = 1'b0; cfg_signed = ~sgn;
        n_cmp++;
        if (busy !== 1'b1 || err_len !== 1'b0 || s_if.tready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start: busy=%b err_len=%b tready=%b, required 1 0 1",
                     tag, busy, err_len, s_if.tready);
        end
        for (int b = 0; b < 32; b++)
            send_beat(b < 16 ? a_v[b] : b_v[b-16], (b == 31) && last_ok);
        n_cmp++;
        if (s_if.tready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_tready_drop: tready=%b, required 0", tag, s_if.tready);
        end
        lat = 0;
        while (m_if.tvalid !== 1'b1 && lat < 100) begin
            start = (poke && lat == 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL %s_latency: %0d cycles, required 4", tag, lat);
        end
        got = 0; guard = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        while (got < 16 && guard < 400) begin
            m_if.tready = bp ? (((guard / 3) % 2) == 1) : 1'b1;
            if (m_if.tvalid === 1'b1) begin
                if (prev_stall) begin
                    n_cmp++;
                    if (m_if.tdata !== prev_d || m_if.tlast !== prev_l) begin
                        n_bad++;
                        $display("FAIL %s_stall_hold: data=%h last=%b, required %h %b",
                                 tag, m_if.tdata, m_if.tlast, prev_d, prev_l);
                    end
                end
                if (m_if.tready) begin
                    n_cmp++;
                    if (m_if.tdata !== c_exp[got] || m_if.tlast !== (got == 15)) begin
                        n_bad++;
                        $display("FAIL %s_beat%0d: data=%h last=%b, required %h %b",
                                 tag, got, m_if.tdata, m_if.tlast, c_exp[got], got == 15);
                    end
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = m_if.tdata;
                    prev_l = m_if.tlast;
                end
            end
            @(negedge clk);
            guard++;
        end
        m_if.tready = 1'b0;
        if (got != 16) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_out_timeout: %0d beats, required 16", tag, got);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err_len !== ~last_ok) begin
            n_bad++;
            $display("FAIL %s_done: done=%b busy=%b err_len=%b, required 1 0 %b",
                     tag, done, busy, err_len, ~last_ok);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after_done: done=%b tready=%b tvalid=%b, required 0 0 0",
                     tag, done, s_if.tready, m_if.tvalid);
        end
    endtask

    task automatic set_identity();
        for (int x = 0; x < 16; x++) begin
            a_v[x]   = (x / 4 == x % 4) ? 16'd1 : 16'd0;
            b_v[x]   = 16'(x);
            c_exp[x] = 32'(x);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({busy, done, err_len, s_if.tready, m_if.tvalid, m_if.tlast} !== 6'b0
            || m_if.tdata !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: busy/done/err/srdy/mvld/mlast=%b data=%h, required all 0",
                     tag, {busy, done, err_len, s_if.tready, m_if.tvalid, m_if.tlast},
                     m_if.tdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_main");
        n_cmp++;
        if ({busy2, done2, err2, s2_if.tready, m2_if.tvalid, m2_if.tlast} !== 6'b0
            || m2_if.tdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rect: flags=%b data=%h, required all 0",
                     {busy2, done2, err2, s2_if.tready, m2_if.tvalid, m2_if.tlast},
                     m2_if.tdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        set_identity();
        run_job(1'b0, 1'b0, 1'b1, 1'b0, "identity");
    endtask

    task automatic test_signed();
        for (int x = 0; x < 16; x++) begin
            a_v[x] = 16'hFFFF; b_v[x] = 16'h0002; c_exp[x] = 32'hFFFF_FFF8;
        end
        run_job(1'b1, 1'b0, 1'b1, 1'b0, "signed");
        for (int x = 0; x < 16; x++) c_exp[x] = 32'h0007_FFF8;
        run_job(1'b0, 1'b0, 1'b1, 1'b0, "unsigned");
    endtask

    task automatic test_backpressure();
        for (int x = 0; x < 16; x++) begin
            a_v[x] = 16'(x + 1);
            b_v[x] = 16'(3 * x + 5);
        end
        model(4, 4, 4, 1'b0);
        run_job(1'b0, 1'b1, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_missing_tlast();
        set_identity();
        run_job(1'b0, 1'b0, 1'b0, 1'b0, "missing_tlast");
    endtask

    task automatic test_early_tlast();
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 10; b++) send_beat(16'(b), b == 9);
        n_cmp++;
        if (err_len !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || s_if.tready !== 1'b0) begin
            n_bad++;
            $display("FAIL early_tlast: err=%b busy=%b done=%b tready=%b, required 1 0 0 0",
                     err_len, busy, done, s_if.tready);
        end
        repeat (20) begin
            @(negedge clk);
            if (m_if.tvalid !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen || err_len !== 1'b1) begin
            n_bad++;
            $display("FAIL early_tlast_quiet: output_seen=%b err=%b, required 0 1",
                     seen, err_len);
        end
        set_identity();
        run_job(1'b0, 1'b0, 1'b1, 1'b0, "after_abort");
    endtask

    task automatic test_start_ignored();
        for (int x = 0; x < 16; x++) begin
            a_v[x] = 16'hFFFF; b_v[x] = 16'h0002; c_exp[x] = 32'hFFFF_FFF8;
        end
        run_job(1'b1, 1'b0, 1'b1, 1'b1, "start_ignored");
    endtask

    task automatic test_rst_mid_load();
        @(negedge clk);
        start = 1'b1; cfg_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 20; b++) send_beat(16'(b + 100), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid_load");
        rst = 1'b0;
        set_identity();
        run_job(1'b0, 1'b0, 1'b1, 1'b0, "after_rst");
    endtask

    task automatic test_rectangular();
        int t0, got, guard, w;
        for (int x = 0; x < 16; x++) begin
            a_v[x] = 16'(x * 1234 + 7);
            b_v[x] = 16'(x * 4321 + 99);
        end
        model(2, 3, 5, 1'b1);
        @(negedge clk);
        start2 = 1'b1; cfg2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; cfg2 = 1'b0;
        t0 = cyc;
        for (int b = 0; b < 21; b++) begin
            s2_if.tvalid = 1'b1;
            s2_if.tdata  = (b < 6) ? a_v[b] : b_v[b-6];
            s2_if.tlast  = (b == 20);
            w = 0;
            while (s2_if.tready !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
        end
        s2_if.tvalid = 1'b0; s2_if.tlast = 1'b0;
        m2_if.tready = 1'b1;
        got = 0; guard = 0;
        while (got < 10 && guard < 200) begin
            if (m2_if.tvalid === 1'b1) begin
                n_cmp++;
                if (m2_if.tdata !== c_exp[got] || m2_if.tlast !== (got == 9)) begin
                    n_bad++;
                    $display("FAIL rect_beat%0d: data=%h last=%b, required %h %b",
                             got, m2_if.tdata, m2_if.tlast, c_exp[got], got == 9);
                end
                got++;
            end
            @(negedge clk);
            guard++;
        end
        m2_if.tready = 1'b0;
        n_cmp++;
        if (got != 10 || done2 !== 1'b1 || (cyc - t0) != 37 || err2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rect_latency: beats=%0d done=%b cycles=%0d err=%b, required 10 1 37 0",
                     got, done2, cyc - t0, err2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_signed = 1'b0; start2 = 1'b0; cfg2 = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0; m2_if.tready = 1'b0;
        test_reset();
        test_identity();
        test_signed();
        test_backpressure();
        test_missing_tlast();
        test_early_tlast();
        test_start_ignored();
        test_rst_mid_load();
        test_rectangular();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
